// File: rtl/hc148_event_decoder.sv
// Receive side of an HC148 priority encoder: synchronise and debounce {Code,GS,EO},
// rebuild the active-low line vector and queue index changes in an event FIFO.
module hc148_event_decoder #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [2:0]                  Code,
   input  logic                        GS,
   input  logic                        EO,
   input  logic                        Clear,
   output logic [7:0]                  DataOut,
   output logic                        Active,
   output logic                        Fault,
   output logic                        EvtValid,
   input  logic                        EvtReady,
   output logic [2:0]                  EvtCode,
   output logic [$clog2(FIFO_DEPTH):0] EvtCount,
   output logic                        Overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES - 1);
   localparam logic [4:0]  DISABLED_VEC = 5'b11111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_FAULT
   } state_t;

   logic [4:0]    sync1, samp, filt;
   logic [7:0]    stable_cnt;
   state_t        state;
   logic [2:0]    last_idx;
   logic [2:0]    idx;
   logic          f_active, f_illegal, push;
   logic [2:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          full, pop, wr_en;

   // The incoming sample (sync1) is compared with the current one so that
   // F is updated exactly 2 + STABLE_CYCLES cycles after an input change.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= DISABLED_VEC;
         samp       <= DISABLED_VEC;
         filt       <= DISABLED_VEC;
         stable_cnt <= '0;
      end else begin
         sync1 <= {Code, GS, EO};
         samp  <= sync1;
         if (sync1 != samp) begin
            stable_cnt <= '0;
         end else if (stable_cnt != CNT_MAX) begin
            stable_cnt <= stable_cnt + 8'd1;
         end else begin
            filt <= samp;
         end
      end
   end

   always_comb begin
      idx       = ~filt[4:2];
      f_active  = !filt[1] && filt[0];
      f_illegal = !filt[1] && !filt[0];
      push      = f_active && ((state != ST_ACTIVE) || (idx != last_idx));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         last_idx <= '0;
         DataOut  <= '1;
         Active   <= 1'b0;
         Fault    <= 1'b0;
      end else begin
         DataOut <= f_active ? ~(8'b1 << idx) : 8'hFF;
         Active  <= f_active;
         Fault   <= f_illegal;
         if (f_illegal) begin
            state <= ST_FAULT;
         end else if (f_active) begin
            state    <= ST_ACTIVE;
            last_idx <= idx;
         end else begin
            state <= ST_IDLE;
         end
      end
   end

   assign full     = (EvtCount == FULL_COUNT);
   assign EvtValid = (EvtCount != '0);
   assign pop      = EvtValid && EvtReady;
   assign wr_en    = push && (!full || pop);
   assign EvtCode  = EvtValid ? mem[rd_ptr] : 3'd0;

   always_ff @(posedge clk) begin
      if (!rst && !Clear && wr_en) begin
         mem[wr_ptr] <= idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || Clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         EvtCount <= '0;
         Overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && full && !pop) begin
            Overflow <= 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   EvtCount <= EvtCount + (AW + 1)'(1);
            2'b01:   EvtCount <= EvtCount - (AW + 1)'(1);
            default: EvtCount <= EvtCount;
         endcase
      end
   end

endmodule
